// File: rtl/rocc_arb_pkg.sv
// rocc_arb_pkg: shared types and helpers for the RoCC command arbiter.
//   MaxReq   - largest supported requester count; sizes requester IDs.
//   IdWidth  - width of a requester ID.
//   id_t     - requester ID type.
//   rr_pick  - round-robin search: first set bit of valid_mask at or after
//              ptr, wrapping modulo n. Returns {found, idx}.
package rocc_arb_pkg;

  // IDs are sized for the largest supported cluster (8 requesters), so the
  // package does not depend on a particular instance's NrReq.
  localparam int unsigned MaxReq  = 8;
  localparam int unsigned IdWidth = $clog2(MaxReq);

  typedef logic [IdWidth-1:0] id_t;

  typedef struct packed {
    logic found;
    id_t  idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] valid_mask,
                                       input id_t ptr,
                                       input int unsigned n);
    rr_pick_t    res;
    int unsigned c;
    res = '0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      c = {{(32-IdWidth){1'b0}}, ptr} + i;
      if (c >= n) c = c - n;
      if (i < n && !res.found && valid_mask[c[IdWidth-1:0]]) begin
        res.found = 1'b1;
        res.idx   = c[IdWidth-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rocc_cmd_arbiter_fifo.sv
// rocc_id_fifo: in-order FIFO of requester IDs awaiting a response.
//   clk_i, reset_l  clock, async active-low reset (FIFO empties)
//   push, din       write an ID (ignored when full)
//   pop             drop the head ID (ignored when empty)
//   full, empty     status from the registered count
//   head            oldest ID
// Depth must be a power of 2 and at least 2; pointers wrap naturally.
module rocc_id_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             reset_l,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [PtrW:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == (PtrW+1)'(Depth));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_push_full : assert property (@(posedge clk_i) disable iff (!reset_l) !(push && full));
  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!reset_l) !(pop && empty));

endmodule

// File: rtl/rocc_cmd_arbiter.sv
// rocc_cmd_arbiter: shares one RoCC accelerator between NrReq requesters.
// Round-robin command arbitration with grant lock while the accelerator
// stalls; IDs of response-expecting commands are queued in order and used
// to steer each accelerator response back to its originator.
// Ports:
//   clk_i, reset_l         clock, async active-low reset
//   req_cmd_i/_xd_i/_valid_i/_ready_o   per-requester command channels
//   req_resp_o, req_resp_valid_o, req_resp_ready_i   response to requesters
//   acc_cmd_o/_valid_o/_ready_i         accelerator command port
//   acc_resp_i/_valid_i/_ready_o        accelerator response port
//   orphan_resp_o          sticky: response seen with nothing outstanding
//   perf_cmd_cnt_o         per-requester accepted-command counters, only
//                          when ROCC_ARB_PERF_EN is defined
module rocc_cmd_arbiter
  import rocc_arb_pkg::*;
#(
  parameter int unsigned NrReq          = 2,
  parameter int unsigned CmdWidth       = 128,
  parameter int unsigned RespWidth      = 69,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_l,
  input  logic [NrReq*CmdWidth-1:0] req_cmd_i,
  input  logic [NrReq-1:0]          req_cmd_xd_i,
  input  logic [NrReq-1:0]          req_cmd_valid_i,
  output logic [NrReq-1:0]          req_cmd_ready_o,
  output logic [RespWidth-1:0]      req_resp_o,
  output logic [NrReq-1:0]          req_resp_valid_o,
  input  logic [NrReq-1:0]          req_resp_ready_i,
  output logic [CmdWidth-1:0]       acc_cmd_o,
  output logic                      acc_cmd_valid_o,
  input  logic                      acc_cmd_ready_i,
  input  logic [RespWidth-1:0]      acc_resp_i,
  input  logic                      acc_resp_valid_i,
  output logic                      acc_resp_ready_o,
  output logic                      orphan_resp_o
`ifdef ROCC_ARB_PERF_EN
  ,
  output logic [NrReq*32-1:0]       perf_cmd_cnt_o
`endif
);

  id_t              rr_ptr_q, lock_idx_q, win_idx, fifo_head;
  logic             lock_q, orphan_q;
  logic [MaxReq-1:0] cand_mask;
  rr_pick_t         pick;
  logic             win_valid, win_xd, cmd_hs;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;

  // A response-expecting command cannot be granted without a free FIFO slot.
  always_comb begin
    cand_mask = '0;
    win_xd    = 1'b0;
    for (int k = 0; k < NrReq; k++) begin
      cand_mask[k] = req_cmd_valid_i[k] & ~(req_cmd_xd_i[k] & fifo_full);
      if (win_idx == id_t'(k)) win_xd = req_cmd_xd_i[k];
    end
  end

  assign pick      = rr_pick(cand_mask, rr_ptr_q, NrReq);
  assign win_idx   = lock_q ? lock_idx_q : pick.idx;
  assign win_valid = reset_l & (lock_q | pick.found);
  assign cmd_hs    = win_valid & acc_cmd_ready_i;
  assign fifo_push = cmd_hs & win_xd;

  always_comb begin
    acc_cmd_o       = '0;
    req_cmd_ready_o = '0;
    for (int k = 0; k < NrReq; k++) begin
      if (win_valid && win_idx == id_t'(k)) acc_cmd_o = req_cmd_i[k*CmdWidth +: CmdWidth];
      req_cmd_ready_o[k] = cmd_hs && (win_idx == id_t'(k));
    end
  end
  assign acc_cmd_valid_o = win_valid;

  // With nothing outstanding the response is swallowed and flagged.
  always_comb begin
    req_resp_valid_o = '0;
    acc_resp_ready_o = 1'b0;
    fifo_pop         = 1'b0;
    if (reset_l) begin
      if (!fifo_empty) begin
        for (int k = 0; k < NrReq; k++) begin
          if (fifo_head == id_t'(k)) begin
            req_resp_valid_o[k] = acc_resp_valid_i;
            acc_resp_ready_o    = req_resp_ready_i[k];
          end
        end
        fifo_pop = acc_resp_valid_i & acc_resp_ready_o;
      end else begin
        acc_resp_ready_o = 1'b1;
      end
    end
  end
  assign req_resp_o    = acc_resp_i;
  assign orphan_resp_o = orphan_q;

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      orphan_q   <= 1'b0;
    end else begin
      if (cmd_hs) begin
        rr_ptr_q <= (win_idx == id_t'(NrReq-1)) ? '0 : win_idx + 1'b1;
        lock_q   <= 1'b0;
      end else if (win_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= win_idx;
      end
      if (acc_resp_valid_i && fifo_empty) orphan_q <= 1'b1;
    end
  end

  rocc_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdWidth)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .reset_l (reset_l),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (win_idx),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

`ifdef ROCC_ARB_PERF_EN
  logic [31:0] perf_cnt_q [NrReq];
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      for (int k = 0; k < NrReq; k++) perf_cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NrReq; k++)
        if (cmd_hs && win_idx == id_t'(k)) perf_cnt_q[k] <= perf_cnt_q[k] + 32'd1;
    end
  end
  always_comb begin
    perf_cmd_cnt_o = '0;
    for (int k = 0; k < NrReq; k++) perf_cmd_cnt_o[k*32 +: 32] = perf_cnt_q[k];
  end
`endif

  a_cmd_stable : assert property (@(posedge clk_i) disable iff (!reset_l)
    (acc_cmd_valid_o && !acc_cmd_ready_i) |=> (acc_cmd_valid_o && $stable(acc_cmd_o)));

endmodule

// File: tb/tb_rocc_cmd_arbiter.sv
// Directed bench for rocc_cmd_arbiter (2 requesters, FIFO depth 4).
module tb_rocc_cmd_arbiter;
  localparam int NrReq = 2, CmdWidth = 128, RespWidth = 69, MaxOutstanding = 4;

  logic                      clk_i = 1'b0;
  logic                      reset_l = 1'b0;
  logic [NrReq*CmdWidth-1:0] req_cmd_i = '0;
  logic [NrReq-1:0]          req_cmd_xd_i = '0, req_cmd_valid_i = '0, req_cmd_ready_o;
  logic [RespWidth-1:0]      req_resp_o;
  logic [NrReq-1:0]          req_resp_valid_o, req_resp_ready_i = '0;
  logic [CmdWidth-1:0]       acc_cmd_o;
  logic                      acc_cmd_valid_o, acc_cmd_ready_i = 1'b0;
  logic [RespWidth-1:0]      acc_resp_i = '0;
  logic                      acc_resp_valid_i = 1'b0, acc_resp_ready_o, orphan_resp_o;
`ifdef ROCC_ARB_PERF_EN
  logic [NrReq*32-1:0]       perf_cmd_cnt_o;
`endif

  int vectors = 0, miscompares = 0;

  rocc_cmd_arbiter #(.NrReq(NrReq), .CmdWidth(CmdWidth), .RespWidth(RespWidth),
                     .MaxOutstanding(MaxOutstanding)) dut (
    .clk_i(clk_i), .reset_l(reset_l),
    .req_cmd_i(req_cmd_i), .req_cmd_xd_i(req_cmd_xd_i),
    .req_cmd_valid_i(req_cmd_valid_i), .req_cmd_ready_o(req_cmd_ready_o),
    .req_resp_o(req_resp_o), .req_resp_valid_o(req_resp_valid_o),
    .req_resp_ready_i(req_resp_ready_i),
    .acc_cmd_o(acc_cmd_o), .acc_cmd_valid_o(acc_cmd_valid_o),
    .acc_cmd_ready_i(acc_cmd_ready_i),
    .acc_resp_i(acc_resp_i), .acc_resp_valid_i(acc_resp_valid_i),
    .acc_resp_ready_o(acc_resp_ready_o), .orphan_resp_o(orphan_resp_o)
`ifdef ROCC_ARB_PERF_EN
    , .perf_cmd_cnt_o(perf_cmd_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cmd(input int k, input logic [CmdWidth-1:0] v);
    req_cmd_i[k*CmdWidth +: CmdWidth] = v;
  endtask

  // Checks the command side of a cycle: expected one-hot ready and payload.
  task automatic chk_cmd(input string tag, input logic vld, input logic [1:0] rdy,
                         input logic [CmdWidth-1:0] data);
    #1;
    check({tag, "_valid"}, 128'(acc_cmd_valid_o), 128'(vld));
    check({tag, "_ready"}, 128'(req_cmd_ready_o), 128'(rdy));
    check({tag, "_data"},  128'(acc_cmd_o),       128'(data));
  endtask

  // Checks the response side of a cycle.
  task automatic chk_resp(input string tag, input logic [1:0] vld, input logic rdy);
    #1;
    check({tag, "_rvalid"}, 128'(req_resp_valid_o), 128'(vld));
    check({tag, "_rready"}, 128'(acc_resp_ready_o), 128'(rdy));
  endtask

  initial begin
    #3000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    check("rst_cmd_valid", 128'(acc_cmd_valid_o), 128'(0));
    check("rst_cmd_ready", 128'(req_cmd_ready_o), 128'(0));
    check("rst_resp_valid", 128'(req_resp_valid_o), 128'(0));
    check("rst_resp_ready", 128'(acc_resp_ready_o), 128'(0));
    check("rst_orphan", 128'(orphan_resp_o), 128'(0));
    #20 reset_l = 1'b1;
    tick();

    // 1: single xd command and its response
    set_cmd(0, 128'hA5); req_cmd_xd_i = 2'b01; req_cmd_valid_i = 2'b01; acc_cmd_ready_i = 1'b1;
    chk_cmd("t1_cmd", 1'b1, 2'b01, 128'hA5);
    tick();
    req_cmd_valid_i = 2'b00; req_cmd_xd_i = 2'b00;
    acc_resp_i = 69'h3C; acc_resp_valid_i = 1'b1; req_resp_ready_i = 2'b11;
    chk_resp("t1_resp", 2'b01, 1'b1);
    check("t1_resp_data", 128'(req_resp_o), 128'h3C);
    tick();
    acc_resp_valid_i = 1'b0; req_resp_ready_i = 2'b00;
    chk_resp("t1_empty", 2'b00, 1'b1);

    // 2: alternate grants; first a requester-1 command brings the pointer to 0
    set_cmd(0, 128'h10); set_cmd(1, 128'h11); req_cmd_valid_i = 2'b10;
    chk_cmd("t2_pre", 1'b1, 2'b10, 128'h11);
    tick();
    req_cmd_valid_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      chk_cmd($sformatf("t2_g%0d", i), 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10,
              (i % 2 == 0) ? 128'h10 : 128'h11);
      tick();
    end

    // 3: grant lock while the accelerator stalls
    req_cmd_valid_i = 2'b10; set_cmd(1, 128'h77); set_cmd(0, 128'h66); acc_cmd_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_cmd($sformatf("t3_stall%0d", i), 1'b1, 2'b00, 128'h77);
      tick();
    end
    req_cmd_valid_i = 2'b11;
    chk_cmd("t3_locked", 1'b1, 2'b00, 128'h77);
    tick();
    acc_cmd_ready_i = 1'b1;
    chk_cmd("t3_hs", 1'b1, 2'b10, 128'h77);
    tick();
    req_cmd_valid_i = 2'b01;
    chk_cmd("t3_next", 1'b1, 2'b01, 128'h66);
    tick();

    // 4: FIFO full blocks xd commands only
    set_cmd(0, 128'h40); set_cmd(1, 128'h41); req_cmd_xd_i = 2'b01; req_cmd_valid_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      chk_cmd($sformatf("t4_fill%0d", i), 1'b1, 2'b01, 128'h40);
      tick();
    end
    req_cmd_valid_i = 2'b11;
    chk_cmd("t4_full_mix", 1'b1, 2'b10, 128'h41);
    tick();
    req_cmd_valid_i = 2'b01; acc_cmd_ready_i = 1'b0;
    chk_cmd("t4_full_block", 1'b0, 2'b00, 128'h0);
    tick();
    acc_cmd_ready_i = 1'b1; acc_resp_i = 69'h55; acc_resp_valid_i = 1'b1; req_resp_ready_i = 2'b11;
    chk_resp("t4_pop", 2'b01, 1'b1);
    check("t4_pop_no_bypass", 128'(acc_cmd_valid_o), 128'(0));
    tick();
    acc_resp_valid_i = 1'b0;
    chk_cmd("t4_after_pop", 1'b1, 2'b01, 128'h40);
    tick();
    req_cmd_valid_i = 2'b00; req_cmd_xd_i = 2'b00; acc_resp_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_resp($sformatf("t4_drain%0d", i), 2'b01, 1'b1);
      tick();
    end
    acc_resp_valid_i = 1'b0; req_resp_ready_i = 2'b00;
    chk_resp("t4_empty", 2'b00, 1'b1);

    // 5: in-order routing 1,0,1 with a stall on requester 0
    req_cmd_xd_i = 2'b11;
    req_cmd_valid_i = 2'b10; chk_cmd("t5_c0", 1'b1, 2'b10, 128'h41); tick();
    req_cmd_valid_i = 2'b01; chk_cmd("t5_c1", 1'b1, 2'b01, 128'h40); tick();
    req_cmd_valid_i = 2'b10; chk_cmd("t5_c2", 1'b1, 2'b10, 128'h41); tick();
    req_cmd_valid_i = 2'b00; req_cmd_xd_i = 2'b00;
    acc_resp_valid_i = 1'b1; acc_resp_i = 69'h101; req_resp_ready_i = 2'b11;
    chk_resp("t5_r1", 2'b10, 1'b1);
    check("t5_r1_data", 128'(req_resp_o), 128'h101);
    tick();
    acc_resp_i = 69'h102; req_resp_ready_i = 2'b10;
    chk_resp("t5_r2_stall", 2'b01, 1'b0);
    tick();
    req_resp_ready_i = 2'b11;
    chk_resp("t5_r2", 2'b01, 1'b1);
    tick();
    acc_resp_i = 69'h103;
    chk_resp("t5_r3", 2'b10, 1'b1);
    tick();

    // 6: orphan response, sticky flag, reset mid-operation
    check("t6_pre_orphan", 128'(orphan_resp_o), 128'(0));
    chk_resp("t6_orphan_resp", 2'b00, 1'b1);
    tick();
    acc_resp_valid_i = 1'b0;
    check("t6_orphan_set", 128'(orphan_resp_o), 128'(1));
    req_cmd_xd_i = 2'b01; req_cmd_valid_i = 2'b01;
    chk_cmd("t6_cmd", 1'b1, 2'b01, 128'h40);
    tick();
    req_cmd_valid_i = 2'b00; req_cmd_xd_i = 2'b00;
    check("t6_orphan_hold", 128'(orphan_resp_o), 128'(1));
    reset_l = 1'b0;
    #1;
    check("t6_rst_orphan", 128'(orphan_resp_o), 128'(0));
    check("t6_rst_rready", 128'(acc_resp_ready_o), 128'(0));
    #1 reset_l = 1'b1;
    tick();
    acc_resp_valid_i = 1'b1;
    chk_resp("t6_discarded", 2'b00, 1'b1);
    tick();
    acc_resp_valid_i = 1'b0;
    check("t6_orphan_again", 128'(orphan_resp_o), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
